// File: rtl/pilha_enderecos.sv
// Return-address / operand LIFO for the multicycle processor.
// Level-held push/pop strobes are edge-detected so each assertion is exactly one stack operation.
module pilha_enderecos #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full,
  output logic [CW-1:0]    o_count,
  output logic             o_overflow,
  output logic             o_underflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_sp;
  logic             r_push_q;
  logic             r_pop_q;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_push_ev;
  logic             w_pop_ev;
  logic             w_empty;
  logic             w_full;
  logic [AW-1:0]    w_top_idx;
  logic             w_wr_en;
  logic [AW-1:0]    w_wr_idx;
  logic [CW-1:0]    w_sp_nxt;
  logic             w_set_ovf;
  logic             w_set_unf;

  assign w_push_ev = i_push & ~r_push_q;
  assign w_pop_ev  = i_pop & ~r_pop_q;
  assign w_empty   = (r_sp == '0);
  assign w_full    = (r_sp == CW'(DEPTH));
  assign w_top_idx = AW'(r_sp - CW'(1));

  // Priority: simultaneous push+pop (replace top), then push, then pop.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_idx  = w_top_idx;
    w_sp_nxt  = r_sp;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    if (w_push_ev && w_pop_ev) begin
      w_wr_en = 1'b1;
      if (w_empty) begin
        w_wr_idx  = '0;
        w_sp_nxt  = CW'(1);
        w_set_unf = 1'b1;
      end
    end else if (w_push_ev) begin
      if (!w_full) begin
        w_wr_en  = 1'b1;
        w_wr_idx = AW'(r_sp);
        w_sp_nxt = r_sp + CW'(1);
      end else begin
        w_set_ovf = 1'b1;
      end
    end else if (w_pop_ev) begin
      if (!w_empty) begin
        w_sp_nxt = r_sp - CW'(1);
      end else begin
        w_set_unf = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sp        <= '0;
      r_push_q    <= 1'b0;
      r_pop_q     <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_sp        <= w_sp_nxt;
      r_push_q    <= i_push;
      r_pop_q     <= i_pop;
      r_overflow  <= r_overflow | w_set_ovf;
      r_underflow <= r_underflow | w_set_unf;
    end
  end

  // Storage is deliberately not reset; sp alone defines which entries are valid.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= i_din;
    end
  end

  assign o_dout      = w_empty ? '0 : r_mem[w_top_idx];
  assign o_empty     = w_empty;
  assign o_full      = w_full;
  assign o_count     = r_sp;
  assign o_overflow  = r_overflow;
  assign o_underflow = r_underflow;

endmodule

// File: tb/tb_pilha_enderecos.sv
// Directed bench for pilha_enderecos (DEPTH=4) with hand-computed expected values.
// Strobes are driven on the falling edge; outputs are sampled on the falling edge after the acting edge.
module tb_pilha_enderecos;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst_n;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;
  logic [CW-1:0]    count;
  logic             overflow;
  logic             underflow;

  int n_checks = 0;
  int n_errors = 0;

  pilha_enderecos #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_push      (push),
    .i_pop       (pop),
    .i_din       (din),
    .o_dout      (dout),
    .o_empty     (empty),
    .o_full      (full),
    .o_count     (count),
    .o_overflow  (overflow),
    .o_underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_push(input logic [31:0] d);
    @(negedge clk);
    push = 1'b1;
    din  = d;
    @(negedge clk);
    push = 1'b0;
  endtask

  task automatic pulse_pop();
    @(negedge clk);
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
  endtask

  task automatic pulse_both(input logic [31:0] d);
    @(negedge clk);
    push = 1'b1;
    pop  = 1'b1;
    din  = d;
    @(negedge clk);
    push = 1'b0;
    pop  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    din   = '0;
    #12;
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_count", 32'(count), 0);
    check_val("rst_empty", 32'(empty), 1);
    check_val("rst_full", 32'(full), 0);
    check_val("rst_dout", dout, 0);
    check_val("rst_ovf", 32'(overflow), 0);
    check_val("rst_unf", 32'(underflow), 0);

    // basic push/pop
    pulse_push(32'h10);
    check_val("p1_dout", dout, 32'h10);
    pulse_push(32'h20);
    pulse_push(32'h30);
    check_val("p3_dout", dout, 32'h30);
    check_val("p3_count", 32'(count), 3);
    pulse_pop();
    check_val("pop1_dout", dout, 32'h20);
    pulse_pop();
    check_val("pop2_dout", dout, 32'h10);
    pulse_pop();
    check_val("pop3_dout", dout, 0);
    check_val("pop3_empty", 32'(empty), 1);
    check_val("pop3_unf", 32'(underflow), 0);

    // fill and overflow
    pulse_push(32'hA1);
    pulse_push(32'hA2);
    pulse_push(32'hA3);
    check_val("fill3_full", 32'(full), 0);
    pulse_push(32'hA4);
    check_val("fill4_full", 32'(full), 1);
    check_val("fill4_count", 32'(count), 4);
    check_val("fill4_ovf", 32'(overflow), 0);
    pulse_push(32'hA5);
    check_val("ovf_flag", 32'(overflow), 1);
    check_val("ovf_dout", dout, 32'hA4);
    check_val("ovf_count", 32'(count), 4);
    pulse_pop();
    check_val("ovf_sticky", 32'(overflow), 1);
    check_val("ovf_pop_dout", dout, 32'hA3);
    do_reset();
    @(negedge clk);
    check_val("rst2_ovf", 32'(overflow), 0);
    check_val("rst2_count", 32'(count), 0);

    // held pop counts once
    pulse_push(32'hAA);
    pulse_push(32'hBB);
    @(negedge clk);
    pop = 1'b1;
    repeat (5) @(negedge clk);
    check_val("hold_dout", dout, 32'hAA);
    check_val("hold_count", 32'(count), 1);
    pop = 1'b0;
    pulse_pop();
    check_val("hold_empty", 32'(empty), 1);
    check_val("hold_unf", 32'(underflow), 0);

    // held push counts once
    @(negedge clk);
    push = 1'b1;
    din  = 32'h55;
    repeat (4) @(negedge clk);
    push = 1'b0;
    check_val("hpush_count", 32'(count), 1);
    pulse_pop();

    // replace top
    pulse_push(32'h1);
    pulse_push(32'h2);
    pulse_both(32'h7);
    check_val("repl_count", 32'(count), 2);
    check_val("repl_dout", dout, 32'h7);
    check_val("repl_unf", 32'(underflow), 0);
    pulse_pop();
    check_val("repl_pop_dout", dout, 32'h1);
    do_reset();

    // underflow, then push+pop on empty
    pulse_pop();
    check_val("unf_flag", 32'(underflow), 1);
    check_val("unf_count", 32'(count), 0);
    pulse_both(32'h5);
    check_val("both_empty_count", 32'(count), 1);
    check_val("both_empty_dout", dout, 32'h5);
    check_val("both_empty_unf", 32'(underflow), 1);
    do_reset();

    // async reset with push held, fresh event after release
    pulse_push(32'h61);
    pulse_push(32'h62);
    pulse_push(32'h63);
    @(negedge clk);
    push = 1'b1;
    din  = 32'h9;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_count", 32'(count), 0);
    check_val("arst_dout", dout, 0);
    check_val("arst_empty", 32'(empty), 1);
    check_val("arst_flags", {30'd0, overflow, underflow}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("rel_count", 32'(count), 1);
    check_val("rel_dout", dout, 32'h9);
    @(negedge clk);
    check_val("rel_hold_count", 32'(count), 1);
    push = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pilha_enderecos.md
# pilha_enderecos

Hardware LIFO stack holding return addresses and stack operands for the multicycle processor. Sits directly downstream of the control unit, and consumes its `push` and `pop` strobes. Sits alongside the PC mux, which reads `dout` as the return target for `jst`. Each level-held strobe is converted into exactly one stack operation, so a `pop` held across a multi-cycle wait state removes only one entry.

## Interface
- `WIDTH`, 32: data/address word width in bits.
- `DEPTH`, 16: number of entries, ≥2.
- `CW`, $clog2(DEPTH+1): width of `count`.

- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `push`  in  1  push request, level from control unit; acted on once per assertion.
- `pop`  in  1  pop request, level from control unit; acted on once per assertion.
- `din`  in  WIDTH  word to push (PC+1 for `jal`, register/ALU value for `lstk`).
- `dout`  out  WIDTH  current top of stack; 0 when empty.
- `empty`  out  1  count == 0.
- `full`  out  1  count == DEPTH.
- `count`  out  CW  number of valid entries.
- `overflow`  out  1  sticky: a push was attempted while full.
- `underflow`  out  1  sticky: a pop was attempted while empty.

## Operation
- Registers: `mem[0..DEPTH-1]`, stack pointer `sp` (= count, 0..DEPTH), `push_q`, `pop_q`, `overflow`, `underflow`.
- Event detection is done every rising edge:
  - `push_ev = push & ~push_q`
  - `pop_ev = pop & ~pop_q`
  - `push_q <= push`, `pop_q <= pop`
- Exactly one of the following actions is taken per edge, in priority order:
  - push_ev & pop_ev & !empty: replace top. Write `mem[sp-1] <= din`; `sp` is unchanged.
  - push_ev & pop_ev & empty: push `din` (`sp` becomes 1); set `underflow`.
  - push_ev & !full: write `mem[sp] <= din`, then `sp <= sp+1`.
  - push_ev & full: no write; `sp` is unchanged; set `overflow`.
  - pop_ev & !empty: `sp <= sp-1`; the entry is not cleared.
  - pop_ev & empty: no change; set `underflow`.
  - no event: hold.
- `dout = empty ? 0 : mem[sp-1]`, combinational from registers.
- `empty`, `full` and `count` are combinational from `sp`.
- `overflow` and `underflow` are cleared only by `reset`.
- Reset values:
  - `sp = 0`, so `count = 0`, `empty = 1`, `full = 0`, `dout = 0`.
  - `push_q = pop_q = 0`; `overflow = underflow = 0`.
  - `mem` is not cleared.
- Reset asserted mid-operation: the stack empties immediately without waiting for a clock edge. If `push`/`pop` are still high when reset deasserts, the next edge counts them as a fresh event, because `push_q`/`pop_q` are 0.

## Timing
- Control strobes change on the falling edge of `clk`; the stack samples on the rising edge, which gives half a cycle of setup.
- A push or pop takes effect on the first rising edge where its strobe is seen high. `dout`, `count` and the flags reflect the new state right after that edge (latency 1 edge).
- `dout` before the pop edge is the popped value. The PC register, loading on the same edge as the pop (`jst`), captures the old top. No bypass is needed.
- A strobe held for N cycles produces one operation. The strobe must drop for at least one sampled edge before it is recognised again.
- Consecutive operations are allowed on alternate edges. There is no fixed throughput limit beyond the one-low-edge requirement above.

## Test plan
- Push 0x10, 0x20, 0x30, each strobe one cycle with gaps, then pop three times.
  - After the pushes: `dout` = 0x30, `count` = 3.
  - After each pop: `dout` = 0x20, then 0x10, then 0; final `empty` = 1, `underflow` = 0.
- DEPTH = 4: push 5 distinct values.
  - `full` = 1 after the 4th push.
  - The 5th push is dropped and sets `overflow` = 1; `dout` stays at the 4th value and `count` = 4.
- Push 0xAA and 0xBB, then hold `pop` high for 5 cycles.
  - Exactly one pop occurs: `dout` = 0xAA, `count` = 1.
  - Dropping `pop` and raising it again pops once more: `empty` = 1.
- Stack holding [0x1, 0x2]: raise `push` and `pop` together with `din` = 0x7.
  - Result: `count` = 2, `dout` = 0x7; pop once more gives `dout` = 0x1.
- Empty stack: pulse `pop`, then pulse `push` and `pop` together with `din` = 0x5.
  - After the first pulse: `underflow` = 1, `count` = 0.
  - After the combined pulse: `count` = 1, `dout` = 0x5.
- Push 3 values, then assert `reset` low between clock edges while `push` is held high.
  - Immediately: `count` = 0, `dout` = 0, flags 0.
  - Release reset with `push` still high and `din` = 0x9: the first edge pushes 0x9, giving `count` = 1.
